// File: rtl/mod_accumulator_pkg.sv
// Shared constants and types for the multi-operand modular accumulator.
// Used by the top and the ripple-carry word adder.
package mod_accumulator_pkg;

    // Default datapath word size (SHA-256 word).
    localparam int WORD_W = 32;

    // Legal operand-count range and the counter width that covers it.
    localparam int NUM_OPS_MIN = 2;
    localparam int NUM_OPS_MAX = 16;
    localparam int CNT_W       = 4;

    // Accumulator control states.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Legality check for an operand-count / width pair.
    function automatic bit cfg_ok(input int width, input int nops);
        return (width % 4 == 0) && (width >= 4) &&
               (nops >= NUM_OPS_MIN) && (nops <= NUM_OPS_MAX);
    endfunction

endpackage

// File: rtl/mod_accumulator_rca_word.sv
// WIDTH-bit ripple-carry adder built from chained 4-bit slices.
// The nibble slice is the leaf cell; rca_word chains them LSB first.
module rca_nibble (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] sum_o,
    output logic       co_o
);

    logic [4:0] c;

    // Four full adders, carry rippling bit to bit.
    always_comb begin
        c     = '0;
        c[0]  = ci_i;
        sum_o = '0;
        for (int i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        co_o = c[4];
    end

endmodule

module rca_word
    import mod_accumulator_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
);

    localparam int NSL = WIDTH / 4;

    logic [NSL:0] carry;

    assign carry[0] = ci_i;

    for (genvar s = 0; s < NSL; s++) begin : g_slice
        rca_nibble u_nib (
            .a_i   (a_i[4*s +: 4]),
            .b_i   (b_i[4*s +: 4]),
            .ci_i  (carry[s]),
            .sum_o (sum_o[4*s +: 4]),
            .co_o  (carry[s+1])
        );
    end

    assign co_o = carry[NSL];

endmodule

// File: rtl/mod_accumulator.sv
// Sequential multi-operand adder mod 2^WIDTH with valid/ready in and out.
// Optional discarded-carry counter enabled by the ACC_CARRY_CNT_EN macro.
module mod_accumulator
    import mod_accumulator_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int NUM_OPS = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [WIDTH-1:0] i_op,
    output logic             o_sum_valid,
    input  logic             i_sum_ready,
`ifdef ACC_CARRY_CNT_EN
    output logic [3:0]       o_carry_cnt,
`endif
    output logic [WIDTH-1:0] o_sum
);

    if (!cfg_ok(WIDTH, NUM_OPS)) begin : g_bad_cfg
        $error("mod_accumulator: illegal WIDTH/NUM_OPS");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);

    acc_state_e       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             op_ready_q;
    logic             sum_valid_q;
    logic             add_co;
    logic             op_hs;
    logic             sum_hs;

    assign op_hs  = i_op_valid & op_ready_q;
    assign sum_hs = sum_valid_q & i_sum_ready;

    rca_word #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (i_op),
        .ci_i  (1'b0),
        .sum_o (acc_d),
        .co_o  (add_co)
    );

`ifdef ACC_CARRY_CNT_EN
    logic [3:0] carry_q;
    logic [3:0] carry_d;

    // Next carry count: bump on a handshake whose add overflowed.
    always_comb begin
        carry_d = carry_q;
        if (op_hs && add_co) begin
            carry_d = carry_q + 4'd1;
        end
    end

    // Carry counter clears with acc on reset and on result handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            carry_q <= '0;
        end else if (sum_hs) begin
            carry_q <= '0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign o_carry_cnt = carry_q;
`else
    logic unused_add_co;
    assign unused_add_co = add_co;
`endif

    // Control FSM with accumulator, operand count and registered handshakes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b1;
            sum_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (op_hs) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST) begin
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                            op_ready_q  <= 1'b0;
                            sum_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (i_sum_ready) begin
                        acc_q       <= '0;
                        state_q     <= ACCUM;
                        op_ready_q  <= 1'b1;
                        sum_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign o_op_ready  = op_ready_q;
    assign o_sum_valid = sum_valid_q;
    assign o_sum       = acc_q;

endmodule

// File: tb/tb_mod_accumulator.sv
// Scoreboard bench for mod_accumulator: directed vectors plus random sums.
// Reference model works on whole operand lists with plain arithmetic.
module tb_mod_accumulator;

    localparam int W    = 32;
    localparam int NOPS = 5;

    typedef struct {
        logic [W-1:0] sum;
        int           carries;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_op_valid = 1'b0;
    logic         o_op_ready;
    logic [W-1:0] i_op = '0;
    logic         o_sum_valid;
    logic         i_sum_ready = 1'b1;
    logic [W-1:0] o_sum;
`ifdef ACC_CARRY_CNT_EN
    logic [3:0]   o_carry_cnt;
`endif

    always #5 clk = ~clk;

    mod_accumulator #(
        .WIDTH   (W),
        .NUM_OPS (NOPS)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_op_valid  (i_op_valid),
        .o_op_ready  (o_op_ready),
        .i_op        (i_op),
        .o_sum_valid (o_sum_valid),
        .i_sum_ready (i_sum_ready),
`ifdef ACC_CARRY_CNT_EN
        .o_carry_cnt (o_carry_cnt),
`endif
        .o_sum       (o_sum)
    );

    int           errors = 0;
    int           checks = 0;
    bit           started = 0;
    bit           hold = 0;
    bit           last_acc = 0;
    bit           rand_rdy = 0;
    int           results = 0;
    logic [W-1:0] ops[$];
    exp_t         expq[$];

    logic [W-1:0] basic[5] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                               32'ha54ff53a, 32'h510e527f};

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_of(input logic [W-1:0] l[$]);
        exp_t   e;
        longint total = 0;
        foreach (l[i]) total += longint'(l[i]);
        e.sum     = total[W-1:0];
        e.carries = int'(total >> W);
        return e;
    endfunction

    // Reference model: consumes operands, forms sums, retires on handshake.
    initial forever begin
        @(posedge clk);
        last_acc = 0;
        if (i_rst) begin
            started = 1;
            hold = 0;
            ops.delete();
            expq.delete();
        end else if (!hold) begin
            if (i_op_valid) begin
                ops.push_back(i_op);
                last_acc = 1;
                if (ops.size() == NOPS) begin
                    expq.push_back(model_of(ops));
                    ops.delete();
                    hold = 1;
                end
            end
        end else if (i_sum_ready) begin
            void'(expq.pop_front());
            results++;
            hold = 0;
        end
    end

    // Monitor: compare handshake flags and sum against the model each cycle.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (started) begin
            chk("op_ready", W'(o_op_ready), W'(!hold));
            chk("sum_valid", W'(o_sum_valid), W'(hold));
            if (hold && expq.size() > 0) e = expq[0];
            else e = model_of(ops);
            chk(hold ? "sum" : "partial", o_sum, e.sum);
`ifdef ACC_CARRY_CNT_EN
            chk("carry_cnt", W'(o_carry_cnt), W'(e.carries));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) i_sum_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] v);
        int n = 0;
        i_op_valid = 1'b1;
        i_op = v;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 60);
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL accept_timeout: operand %h not taken in %0d cycles", v, n);
        end
    endtask

    task automatic idle(input int n);
        i_op_valid = 1'b0;
        i_op = $urandom;
        repeat (n) tick();
    endtask

    task automatic send_basic(input int gap);
        for (int i = 0; i < 5; i++) begin
            send(basic[i]);
            if (gap > 0 && i < 4) idle((i % 2 == 0) ? 1 : gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hs;
        repeat (2) tick();
        i_rst = 1'b0;
        idle(1);
        chk("reset_sum", o_sum, '0);
        chk("reset_ready", W'(o_op_ready), W'(1));

        // Basic vector, ready high.
        send_basic(0);
        idle(1);
        chk("basic_result_cnt", W'(results), W'(1));

        // All-ones wrap-around.
        for (int i = 0; i < 5; i++) send(32'hFFFFFFFF);
        idle(2);

        // Backpressure with junk on the operand bus.
        i_sum_ready = 1'b0;
        send_basic(0);
        i_op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_op = $urandom;
            tick();
        end
        chk("bp_hold_valid", W'(o_sum_valid), W'(1));
        chk("bp_hold_sum", o_sum, 32'h583ED017);
        i_op_valid = 1'b0;
        i_sum_ready = 1'b1;
        tick();
        send_basic(0);
        idle(2);

        // Bubbles of 1 and 4 cycles.
        send_basic(4);
        idle(2);

        // Reset mid-sum.
        send(32'h12345678);
        send(32'h9abcdef0);
        i_op_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        send_basic(0);
        idle(1);
        chk("rst_sum_seen", o_sum, 32'h0);

        // Back-to-back sums; result cycles relative to first handshake.
        first_hs = results;
        for (int i = 0; i < 5; i++) send(basic[i]);
        chk("b2b_valid_c6", W'(o_sum_valid), W'(1));
        chk("b2b_sum1", o_sum, 32'h583ED017);
        for (int i = 0; i < 5; i++) send(32'h1);
        chk("b2b_valid_c12", W'(o_sum_valid), W'(1));
        chk("b2b_sum2", o_sum, 32'h5);
        idle(1);
        chk("b2b_results", W'(results - first_hs), W'(2));

        // Random operands, random gaps, random downstream ready.
        rand_rdy = 1;
        for (int s = 0; s < 15; s++) begin
            for (int i = 0; i < NOPS; i++) begin
                logic [W-1:0] v;
                v = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 | W'($urandom_range(0, 15))
                                                 : W'($urandom);
                send(v);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_rdy = 0;
        i_sum_ready = 1'b1;
        idle(4);
        chk("drain_empty", W'(expq.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_accumulator.md
# mod_accumulator

Sequential multi-operand modular adder that feeds the SHA-256 round datapath. It accepts a fixed number of WIDTH-bit operands one per handshake, such as h, Σ1, Ch, K[t] and W[t] for T1. It sums them modulo 2^WIDTH through one combinational ripple-carry adder built from 4-bit slices, then presents the result downstream over a valid/ready handshake. It sits between the operand-select logic and the working-variable register file.

## Interface
Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of 4
- NUM_OPS, 5, operands per sum; legal range 2..16

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_op_valid  in  1  operand valid
- o_op_ready  out  1  accumulator can accept an operand
- i_op  in  WIDTH  operand data
- o_sum_valid  out  1  result valid
- i_sum_ready  in  1  downstream accepts result
- o_sum  out  WIDTH  result, mod 2^WIDTH
- o_carry_cnt  out  4  carries discarded during this sum; present only with ACC_CARRY_CNT_EN

## Operation
- State machine with two states:
  - ACCUM: o_op_ready=1, o_sum_valid=0.
  - HOLD: o_op_ready=0, o_sum_valid=1.
- Operand handshake: i_op_valid && o_op_ready on a rising edge.
- Each handshake in ACCUM:
  - acc <= acc + i_op, truncated to WIDTH bits.
  - Carry-in is 0; carry-out is discarded.
  - op_cnt increments.
- acc is 0 at the start of every sum, so the first operand loads unchanged.
- On the NUM_OPS-th handshake:
  - op_cnt returns to 0 and the state goes to HOLD.
  - o_sum shows the final acc.
- HOLD:
  - o_sum and o_carry_cnt stay stable while i_sum_ready=0.
  - i_op and i_op_valid are ignored.
- Result handshake, o_sum_valid && i_sum_ready:
  - State goes to ACCUM.
  - acc and the carry count clear to 0 on the same edge.
- i_op_valid low in ACCUM inserts a bubble; acc and op_cnt hold.
- Adder: WIDTH/4 nibble slices chained carry-to-carry, LSB slice first. The full chain is evaluated in a single cycle.
- o_sum is driven directly from acc. In ACCUM it holds the partial sum, and consumers must qualify it with o_sum_valid.

## Timing
- Reset values: state=ACCUM, acc=0, op_cnt=0.
  - Outputs: o_op_ready=1, o_sum_valid=0, o_sum=0, o_carry_cnt=0.
- Reset asserted in any state or mid-sum:
  - The partial sum is discarded.
  - The next operand after reset deasserts is operand 0 of a new sum.
- Latency: o_sum_valid rises the cycle after the final operand handshake.
- Throughput: at most one result per NUM_OPS+1 cycles, because the HOLD cycle is never overlapped with accepting operands.
- i_sum_ready already high on entry to HOLD: HOLD lasts exactly one cycle.
- Critical path: acc → WIDTH/4 slices of carry chain → acc.

## Configuration
- ACC_CARRY_CNT_EN defined:
  - A 4-bit carry counter increments on every operand handshake whose adder carry-out is 1.
  - The counter is exposed on o_carry_cnt and cannot saturate, since at most 15 carries are possible with NUM_OPS ≤ 16.
  - It clears with acc.
- ACC_CARRY_CNT_EN undefined:
  - The o_carry_cnt port and counter do not exist.
  - The carry-out is left unconnected.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - The WIDTH default (word size 32).
  - The state enum (ACCUM, HOLD).
  - The NUM_OPS range-check constants.
- One sub-module, rca_word:
  - A WIDTH-bit ripple-carry adder instantiating WIDTH/4 existing 4-bit slices via generate.
  - Ports: a, b, carry-in, sum, carry-out.
- The top holds the FSM, acc, op_cnt and the optional counter.

## Test plan
- Basic sum: with NUM_OPS=5, feed 0x6a09e667, 0xbb67ae85, 0x3c6ef372, 0xa54ff53a, 0x510e527f back-to-back with i_sum_ready=1.
  - Expect o_sum=0x583ED017 with o_sum_valid high one cycle later.
  - With ACC_CARRY_CNT_EN, expect o_carry_cnt=2.
- Wrap-around: feed 5× 0xFFFFFFFF.
  - Expect o_sum=0xFFFFFFFB and o_carry_cnt=4.
- Backpressure: complete a sum with i_sum_ready=0 for 3 cycles, driving i_op_valid=1 with junk throughout.
  - o_sum stays stable, o_op_ready=0, and no operand is consumed.
  - Release ready; the next sum starts from 0.
- Bubbles: insert i_op_valid=0 gaps of 1 and 4 cycles between the operands of the basic-sum vector.
  - Expect the same 0x583ED017.
- Reset mid-sum: accept 2 operands, assert i_rst for 1 cycle, then feed the basic-sum vector.
  - Expect 0x583ED017, not corrupted by the earlier operands.
- Back-to-back sums: two 5-operand sums with i_sum_ready=1.
  - Results appear at cycles 6 and 12 after the first handshake.
  - The second sum is independent of the first: 5× 0x00000001 gives 0x00000005.
